wavegen_axil_regfile: RTL and testbench
=======================================

Name: wavegen_axil_regfile

Overview:
Parametrised AXI4-Lite slave register file for the wavegen IP. It replaces the fixed four-register slave with a configurable register count, per-register read-only/status mapping, byte strobes, error responses and per-register write pulses. It sits between the PS interconnect and the wavegen core: RW registers drive wave configuration, and RO registers expose core status.

Parameters:
DATA_W, 32, AXI data width; multiple of 8, only 32 supported in v1
ADDR_W, 6, AXI byte-address width; must satisfy 2^(ADDR_W-2) >= NUM_REGS
NUM_REGS, 8, number of 32-bit registers, word-aligned from offset 0x00
RO_MASK, 8'b1100_0000, bit i=1: register i is read-only and reads status_in slice i
RESET_VAL, {NUM_REGS{32'h0}}, flattened per-register reset values (RW registers only)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
AWADDR  in  ADDR_W  write address
AWVALID  in  1  write-address valid
AWREADY  out  1  write-address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WVALID  in  1  write-data valid
WREADY  out  1  write-data ready
BRESP  out  2  write response
BVALID  out  1  write-response valid
BREADY  in  1  write-response ready
ARADDR  in  ADDR_W  read address
ARVALID  in  1  read-address valid
ARREADY  out  1  read-address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready
reg_out  out  NUM_REGS*DATA_W  current RW register contents; RO slices are 0
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on a successful write to register i
status_in  in  NUM_REGS*DATA_W  status values; only RO slices are used

Behaviour:
- Clocking and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg_wr_pulse=0, RW registers=RESET_VAL.
- Reset mid-transaction: any pending AW, W, B or R state is dropped; the FSMs return to idle on the next edge.
- Decode: index = addr[ADDR_W-1:2]; addr[1:0] is ignored.
- Write FSM, W_IDLE / W_RESP:
  - In W_IDLE, AW and W are captured independently. AWREADY drops after the AW handshake and WREADY drops after the W handshake, until the other one arrives.
  - When both are held (including same-cycle arrival), the write executes on that edge and BVALID=1 on the next cycle. Minimum latency is 1 cycle from the last handshake to BVALID.
  - In W_RESP, BVALID and BRESP hold until BREADY. AWREADY=WREADY=0 during W_RESP. On the BVALID&BREADY edge the FSM returns to W_IDLE with both readies high.
- Write effect:
  - index < NUM_REGS and RW: byte k is updated when WSTRB[k]=1. reg_wr_pulse[index]=1 for exactly the cycle after the write edge (concurrent with the first BVALID cycle). BRESP=OKAY (00).
  - WSTRB=0 is OKAY with no change and no pulse.
  - RO register: SLVERR (10), no state change, no pulse.
  - index >= NUM_REGS: DECERR (11), no change, no pulse.
- Read FSM, R_IDLE / R_DATA:
  - ARREADY=1 in R_IDLE. On the AR handshake, RDATA and RRESP are registered and RVALID=1 next cycle. Latency is 1 cycle.
  - RDATA, RRESP and RVALID hold until RREADY. ARREADY=0 in R_DATA.
- Read data:
  - RW register: register value.
  - RO register: status_in slice, sampled at the AR handshake edge.
  - index >= NUM_REGS: RDATA=0, RRESP=DECERR.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- Read and write channels are fully independent, one outstanding transaction each.

Decomposition:
- Shared package wavegen_axil_pkg holds:
  - the resp_t enum: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11
  - the w_state_t and r_state_t enums
  - the REG_BYTES=4 constant
  - function strb_merge(old, data, strb)
- No sub-module. The write and read FSMs live in the single module as separate always_ff blocks.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00–0x0C with full strobes, then read back -> each read returns the written value with RRESP=00. reg_wr_pulse[0..3] each pulses once.
- Write 0xAABBCCDD to 0x04, then 0x11223344 with WSTRB=4'b0011 -> readback 0xAABB3344.
- Drive AW to 0x08 three cycles before W=0x55 -> AWREADY low for those cycles, BVALID one cycle after the W handshake. Hold BREADY low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout.
- Write to 0x18 (RO, index 6) with status_in slice 6 = 0xCAFE0001 -> BRESP=10, no pulse. Read 0x18 -> 0xCAFE0001, RRESP=00.
- Read and write 0x3C (index 15 >= NUM_REGS) -> RRESP=BRESP=11, RDATA=0, no register changes.
- Assert ARESET while BVALID=1 and RVALID=1 -> next cycle BVALID=RVALID=0, all readies=1, registers=RESET_VAL.

Source files
------------

// File: rtl/wavegen_axil_pkg.sv
// Shared types and helpers for the wavegen AXI4-Lite register file.
// Response codes, FSM state encodings and the byte-strobe merge.
package wavegen_axil_pkg;

    localparam int REG_BYTES = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    function automatic logic [8*REG_BYTES-1:0] strb_merge(
        input logic [8*REG_BYTES-1:0] old,
        input logic [8*REG_BYTES-1:0] data,
        input logic [REG_BYTES-1:0]   strb
    );
        logic [8*REG_BYTES-1:0] res;
        res = old;
        for (int k = 0; k < REG_BYTES; k++) begin
            if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wavegen_axil_regfile_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the
// wavegen register file (slave).
interface wavegen_axil_regfile_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    import wavegen_axil_pkg::*;

    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/wavegen_axil_regfile.sv
// AXI4-Lite slave register file for the wavegen core: RW config registers,
// RO status registers, byte strobes, error responses and write pulses.
module wavegen_axil_regfile
    import wavegen_axil_pkg::*;
#(
    parameter int                           DATA_W    = 32,
    parameter int                           ADDR_W    = 6,
    parameter int                           NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]          RO_MASK   = 8'b1100_0000,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    wavegen_axil_regfile_if.slave        axi,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          reg_wr_pulse,
    input  logic [NUM_REGS*DATA_W-1:0]   status_in
);
    localparam int IDX_W = ADDR_W - 2;

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    resp_t                 bresp_q, bresp_d;
    resp_t                 rresp_q, rresp_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];

    logic                  aw_fire, w_fire;
    logic [ADDR_W-1:0]     w_addr_eff;
    logic [DATA_W-1:0]     w_data_eff;
    logic [DATA_W/8-1:0]   w_strb_eff;
    logic [IDX_W-1:0]      w_idx, r_idx;
    logic [NUM_REGS-1:0]   w_hit, r_hit;
    logic                  unused_addr_lsb;

    assign axi.AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
    assign axi.WREADY  = (w_state_q == W_IDLE) && !w_held_q;
    assign axi.BVALID  = (w_state_q == W_RESP);
    assign axi.BRESP   = bresp_q;
    assign axi.ARREADY = (r_state_q == R_IDLE);
    assign axi.RVALID  = (r_state_q == R_DATA);
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;
    assign reg_wr_pulse = pulse_q;

    assign aw_fire = axi.AWVALID && axi.AWREADY;
    assign w_fire  = axi.WVALID && axi.WREADY;
    assign unused_addr_lsb = ^{w_addr_eff[1:0], axi.ARADDR[1:0]};

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        // A channel already held takes priority over the live bus value.
        w_addr_eff = aw_held_q ? awaddr_q : axi.AWADDR;
        w_data_eff = w_held_q  ? wdata_q  : axi.WDATA;
        w_strb_eff = w_held_q  ? wstrb_q  : axi.WSTRB;
        w_idx      = w_addr_eff[ADDR_W-1:2];
        for (int i = 0; i < NUM_REGS; i++) w_hit[i] = (w_idx == IDX_W'(i));
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = axi.AWADDR;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = axi.WDATA;
                    wstrb_d  = axi.WSTRB;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                    if (w_hit == '0) begin
                        bresp_d = DECERR;
                    end else if ((w_hit & RO_MASK) != '0) begin
                        bresp_d = SLVERR;
                    end else begin
                        bresp_d = OKAY;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_hit[i] && (w_strb_eff != '0)) begin
                                regs_d[i]  = strb_merge(regs_q[i], w_data_eff, w_strb_eff);
                                pulse_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (axi.BREADY) begin
                    w_state_d = W_IDLE;
                    bresp_d   = OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_idx     = axi.ARADDR[ADDR_W-1:2];
        for (int i = 0; i < NUM_REGS; i++) r_hit[i] = (r_idx == IDX_W'(i));
        case (r_state_q)
            R_IDLE: begin
                if (axi.ARVALID) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = (r_hit == '0) ? DECERR : OKAY;
                    // regs_q is the pre-write value when a write lands on the same edge.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (r_hit[i]) rdata_d = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_q[i];
                    end
                end
            end
            R_DATA: begin
                if (axi.RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
            regs_q    <= regs_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_wavegen_axil_regfile.sv
// Directed bench for wavegen_axil_regfile: a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_wavegen_axil_regfile;
    import wavegen_axil_pkg::*;

    localparam int TMO = 20;

    logic         ACLK;
    logic         ARESET;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr_pulse;
    logic [255:0] status_in;

    int total = 0;
    int bad   = 0;

    wavegen_axil_regfile_if #(.ADDR_W(6), .DATA_W(32)) axi ();

    wavegen_axil_regfile dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .axi          (axi),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_in    (status_in)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [7:0] pulses, output int lat);
        bit aw_pend, w_pend, aw_hs, w_hs;
        int n;
        @(negedge ACLK);
        axi.AWADDR = a; axi.AWVALID = 1'b1;
        axi.WDATA = d; axi.WSTRB = s; axi.WVALID = 1'b1;
        aw_pend = 1; w_pend = 1; n = 0;
        while ((aw_pend || w_pend) && n < TMO) begin
            aw_hs = axi.AWVALID && axi.AWREADY;
            w_hs  = axi.WVALID && axi.WREADY;
            @(negedge ACLK);
            n++;
            if (aw_hs) begin axi.AWVALID = 1'b0; aw_pend = 0; end
            if (w_hs)  begin axi.WVALID = 1'b0;  w_pend = 0;  end
        end
        if (aw_pend || w_pend) check("write_handshake_timeout", 1, 0);
        lat = 0;
        while (!axi.BVALID && lat < TMO) begin
            @(negedge ACLK);
            lat++;
        end
        resp = axi.BRESP;
        pulses = reg_wr_pulse;
        axi.BREADY = 1'b1;
        @(negedge ACLK);
        axi.BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        bit pend, hs;
        int n;
        @(negedge ACLK);
        axi.ARADDR = a; axi.ARVALID = 1'b1;
        pend = 1; n = 0;
        while (pend && n < TMO) begin
            hs = axi.ARVALID && axi.ARREADY;
            @(negedge ACLK);
            n++;
            if (hs) begin axi.ARVALID = 1'b0; pend = 0; end
        end
        if (pend) check("read_handshake_timeout", 1, 0);
        lat = 0;
        while (!axi.RVALID && lat < TMO) begin
            @(negedge ACLK);
            lat++;
        end
        d = axi.RDATA;
        resp = axi.RRESP;
        axi.RREADY = 1'b1;
        @(negedge ACLK);
        axi.RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0]  rd;
        logic [1:0]   rsp;
        logic [7:0]   pl;
        int           lat;
        logic [255:0] exp_regs;

        ARESET = 1'b1;
        axi.AWADDR = '0; axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0;
        axi.WVALID = 1'b0; axi.BREADY = 1'b0; axi.ARADDR = '0; axi.ARVALID = 1'b0;
        axi.RREADY = 1'b0;
        status_in = {256{1'b1}};
        status_in[6*32 +: 32] = 32'hCAFE_0001;
        status_in[7*32 +: 32] = 32'h0BAD_F00D;

        vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001, 4'hF, 32'h0, 2'b00, 8'h01};
        vecs[1]  = '{1'b1, 6'h04, 32'h0000_0002, 4'hF, 32'h0, 2'b00, 8'h02};
        vecs[2]  = '{1'b1, 6'h08, 32'h0000_0003, 4'hF, 32'h0, 2'b00, 8'h04};
        vecs[3]  = '{1'b1, 6'h0C, 32'h0000_0004, 4'hF, 32'h0, 2'b00, 8'h08};
        vecs[4]  = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 8'h00};
        vecs[5]  = '{1'b0, 6'h04, 32'h0, 4'h0, 32'h0000_0002, 2'b00, 8'h00};
        vecs[6]  = '{1'b0, 6'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00, 8'h00};
        vecs[7]  = '{1'b0, 6'h0C, 32'h0, 4'h0, 32'h0000_0004, 2'b00, 8'h00};
        vecs[8]  = '{1'b1, 6'h04, 32'hAABB_CCDD, 4'hF, 32'h0, 2'b00, 8'h02};
        vecs[9]  = '{1'b1, 6'h04, 32'h1122_3344, 4'h3, 32'h0, 2'b00, 8'h02};
        vecs[10] = '{1'b0, 6'h04, 32'h0, 4'h0, 32'hAABB_3344, 2'b00, 8'h00};
        vecs[11] = '{1'b1, 6'h10, 32'hDEAD_BEEF, 4'h0, 32'h0, 2'b00, 8'h00};
        vecs[12] = '{1'b0, 6'h10, 32'h0, 4'h0, 32'h0000_0000, 2'b00, 8'h00};
        vecs[13] = '{1'b1, 6'h18, 32'h1234_5678, 4'hF, 32'h0, 2'b10, 8'h00};
        vecs[14] = '{1'b0, 6'h18, 32'h0, 4'h0, 32'hCAFE_0001, 2'b00, 8'h00};
        vecs[15] = '{1'b1, 6'h3C, 32'h5555_5555, 4'hF, 32'h0, 2'b11, 8'h00};
        vecs[16] = '{1'b0, 6'h3C, 32'h0, 4'h0, 32'h0000_0000, 2'b11, 8'h00};
        vecs[17] = '{1'b0, 6'h1F, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 8'h00};
        vecs[18] = '{1'b1, 6'h16, 32'h1234_5678, 4'h8, 32'h0, 2'b00, 8'h20};
        vecs[19] = '{1'b0, 6'h15, 32'h0, 4'h0, 32'h1200_0000, 2'b00, 8'h00};

        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        check("rst_awready", axi.AWREADY, 1);
        check("rst_wready", axi.WREADY, 1);
        check("rst_arready", axi.ARREADY, 1);
        check("rst_bvalid", axi.BVALID, 0);
        check("rst_rvalid", axi.RVALID, 0);
        check("rst_resps", {axi.BRESP, axi.RRESP}, 0);
        check("rst_rdata", axi.RDATA, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        check("rst_reg_out", reg_out, 0);

        for (int v = 0; v < 20; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, rsp, pl, lat);
                check($sformatf("vec%0d_bresp", v), rsp, vecs[v].exp_resp);
                check($sformatf("vec%0d_pulse", v), pl, vecs[v].exp_pulse);
                check($sformatf("vec%0d_blat", v), lat, 0);
            end else begin
                do_read(vecs[v].addr, rd, rsp, lat);
                check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_data);
                check($sformatf("vec%0d_rresp", v), rsp, vecs[v].exp_resp);
                check($sformatf("vec%0d_rlat", v), lat, 0);
            end
        end

        // AW arrives three cycles ahead of W, then B is back-pressured.
        @(negedge ACLK);
        axi.AWADDR = 6'h08; axi.AWVALID = 1'b1;
        @(negedge ACLK);
        axi.AWVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("early_aw_awready", axi.AWREADY, 0);
            check("early_aw_wready", axi.WREADY, 1);
            check("early_aw_bvalid", axi.BVALID, 0);
            @(negedge ACLK);
        end
        axi.WDATA = 32'h55; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        @(negedge ACLK);
        axi.WVALID = 1'b0;
        check("late_w_bvalid", axi.BVALID, 1);
        check("late_w_pulse", reg_wr_pulse, 8'h04);
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid", axi.BVALID, 1);
            check("bp_bresp", axi.BRESP, 2'b00);
            check("bp_readies", {axi.AWREADY, axi.WREADY}, 2'b00);
            if (k > 0) check("bp_pulse_gone", reg_wr_pulse, 0);
            @(negedge ACLK);
        end
        axi.BREADY = 1'b1;
        @(negedge ACLK);
        axi.BREADY = 1'b0;
        check("bp_release_bvalid", axi.BVALID, 0);
        check("bp_release_readies", {axi.AWREADY, axi.WREADY}, 2'b11);
        do_read(6'h08, rd, rsp, lat);
        check("bp_readback", rd, 32'h55);

        // Same-edge read and write to register 0: read sees the old value.
        @(negedge ACLK);
        axi.AWADDR = 6'h00; axi.AWVALID = 1'b1;
        axi.WDATA = 32'h99; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        axi.ARADDR = 6'h00; axi.ARVALID = 1'b1;
        @(negedge ACLK);
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
        check("rw_same_rvalid", axi.RVALID, 1);
        check("rw_same_bvalid", axi.BVALID, 1);
        check("rw_same_rdata_old", axi.RDATA, 32'h1);
        axi.BREADY = 1'b1; axi.RREADY = 1'b1;
        @(negedge ACLK);
        axi.BREADY = 1'b0; axi.RREADY = 1'b0;
        do_read(6'h00, rd, rsp, lat);
        check("rw_same_new", rd, 32'h99);

        exp_regs = '0;
        exp_regs[0*32 +: 32] = 32'h0000_0099;
        exp_regs[1*32 +: 32] = 32'hAABB_3344;
        exp_regs[2*32 +: 32] = 32'h0000_0055;
        exp_regs[3*32 +: 32] = 32'h0000_0004;
        exp_regs[5*32 +: 32] = 32'h1200_0000;
        check("reg_out_final", reg_out, exp_regs);

        // Reset while both B and R are pending.
        @(negedge ACLK);
        axi.AWADDR = 6'h0C; axi.AWVALID = 1'b1;
        axi.WDATA = 32'h77; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
        axi.ARADDR = 6'h04; axi.ARVALID = 1'b1;
        @(negedge ACLK);
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
        check("pre_rst_valids", {axi.BVALID, axi.RVALID}, 2'b11);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("mid_rst_valids", {axi.BVALID, axi.RVALID}, 2'b00);
        check("mid_rst_readies", {axi.AWREADY, axi.WREADY, axi.ARREADY}, 3'b111);
        check("mid_rst_reg_out", reg_out, 0);
        check("mid_rst_pulse", reg_wr_pulse, 0);
        check("mid_rst_rdata", axi.RDATA, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
